// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and enums for the memory block mover
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mover_state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } mover_mode_t;

endpackage

// File: rtl/mem_block_mover_if.sv
// rtl/mem_block_mover_if.sv - single-port data memory access bus
interface mem_block_mover_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic [ADDR_W-1:0] memAddress;
    logic              memWriteEn;
    logic [DATA_W-1:0] memDataOut;
    logic [DATA_W-1:0] memDataIn;

    // master drives the memory, slave is the memory itself
    modport master (
        output memAddress,
        output memWriteEn,
        output memDataOut,
        input  memDataIn
    );

    modport slave (
        input  memAddress,
        input  memWriteEn,
        input  memDataOut,
        output memDataIn
    );
endinterface

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - block copy / fill engine for the 256-byte data memory
module mem_block_mover
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [ADDR_W-1:0]  srcAddr,
    input  logic [ADDR_W-1:0]  dstAddr,
    input  logic [ADDR_W-1:0]  length,
    input  logic [DATA_W-1:0]  fillValue,
    mem_block_mover_if.master  mem,
    output logic               busy,
    output logic               done
);

    mover_state_t      state;
    mover_mode_t       mode_q;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] fill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= COPY;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            hold      <= '0;
            fill_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mover_mode_t'(mode);
                        src       <= srcAddr;
                        dst       <= dstAddr;
                        remaining <= length;
                        fill_q    <= fillValue;
                        if (length == '0)
                            state <= DONE;
                        else if (mover_mode_t'(mode) == FILL)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    hold  <= mem.memDataIn;
                    state <= WRITE;
                end
                WRITE: begin
                    // pointers wrap naturally at the address width
                    src       <= src + 1'b1;
                    dst       <= dst + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == ADDR_W'(1))
                        state <= DONE;
                    else if (mode_q == FILL)
                        state <= WRITE;
                    else
                        state <= READ;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // bus outputs are pure decodes of state and held registers, so they never glitch onto a write
    always_comb begin
        mem.memAddress = '0;
        mem.memWriteEn = 1'b0;
        mem.memDataOut = '0;
        case (state)
            READ: mem.memAddress = src;
            WRITE: begin
                mem.memAddress = dst;
                mem.memWriteEn = 1'b1;
                mem.memDataOut = (mode_q == FILL) ? fill_q : hold;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - self-checking bench for mem_block_mover with a 256-byte memory model
module tb_mem_block_mover;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] length;
    logic [7:0] fillValue;
    logic       busy;
    logic       done;

    mem_block_mover_if bus ();

    mem_block_mover dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .length    (length),
        .fillValue (fillValue),
        .mem       (bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    assign bus.memDataIn = mem[bus.memAddress];
    always @(posedge clk) if (bus.memWriteEn) mem[bus.memAddress] <= bus.memDataOut;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_wr_t;

    typedef struct {
        logic       mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
        int         exp_lat;
        logic       poke;
    } vec_t;

    exp_wr_t sb[$];
    int      errors = 0;
    int      checks = 0;
    int      wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every write cycle on the bus must match the next expected write
    always @(negedge clk) begin
        if (bus.memWriteEn) begin
            wr_count++;
            if (sb.size() == 0) begin
                check("unexpected_write_addr", {24'd0, bus.memAddress}, 32'hFFFF_FFFF);
            end else begin
                exp_wr_t e;
                e = sb.pop_front();
                check("write_addr", {24'd0, bus.memAddress}, {24'd0, e.addr});
                check("write_data", {24'd0, bus.memDataOut}, {24'd0, e.data});
            end
        end
    end

    // forward byte-by-byte reference: reads see bytes already rewritten by this transfer
    task automatic push_expected(input vec_t v, input int count);
        for (int i = 0; i < count; i++) begin
            logic [7:0] s, d, val;
            exp_wr_t e;
            s = v.src + 8'(i);
            d = v.dst + 8'(i);
            val = v.mode ? v.fill : ref_mem[s];
            ref_mem[d] = val;
            e.addr = d;
            e.data = val;
            sb.push_back(e);
        end
    endtask

    task automatic compare_mem(input string name);
        int mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check(name, mism, 0);
    endtask

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        start = 1'b1; mode = v.mode; srcAddr = v.src; dstAddr = v.dst;
        length = v.len; fillValue = v.fill;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 1'($urandom); srcAddr = 8'($urandom); dstAddr = 8'($urandom);
        length = 8'($urandom); fillValue = 8'($urandom);
    endtask

    task automatic run(input vec_t v);
        int lat = 0;
        int busy_cnt = 0;
        int w0;
        push_expected(v, int'(v.len));
        w0 = wr_count;
        drive_start(v);
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin lat = c; break; end
            if (v.poke && c == 2) begin
                start = 1'b1; mode = 1'b0; srcAddr = 8'h00; dstAddr = 8'hC0; length = 8'h08;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_latency", lat, v.exp_lat);
        check("busy_cycles", busy_cnt, v.exp_lat);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 0);
        check("busy_after", {31'd0, busy}, 0);
        check("write_count", wr_count - w0, int'(v.len));
        check("sb_drained", sb.size(), 0);
        compare_mem("mem_contents");
    endtask

    vec_t vecs[9];

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        srcAddr = '0; dstAddr = '0; length = '0; fillValue = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h40] = 8'h77;
        ref_mem[8'h20] = 8'h11; ref_mem[8'h21] = 8'h22; ref_mem[8'h22] = 8'h33; ref_mem[8'h40] = 8'h77;

        //          mode  src    dst    len    fill   lat  poke
        vecs[0] = '{1'b1, 8'h00, 8'h10, 8'd4,  8'hA5, 5,   1'b0};
        vecs[1] = '{1'b0, 8'h20, 8'h80, 8'd3,  8'h00, 7,   1'b0};
        vecs[2] = '{1'b1, 8'h00, 8'hFE, 8'd3,  8'h5C, 4,   1'b0};
        vecs[3] = '{1'b0, 8'h40, 8'h41, 8'd3,  8'h00, 7,   1'b0};
        vecs[4] = '{1'b0, 8'h33, 8'h44, 8'd0,  8'h00, 1,   1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h60, 8'd5,  8'h3E, 6,   1'b1};
        vecs[6] = '{1'b0, 8'hF0, 8'h05, 8'd20, 8'h00, 41,  1'b1};
        vecs[7] = '{1'b0, 8'h30, 8'h30, 8'd2,  8'h00, 5,   1'b0};
        vecs[8] = '{1'b1, 8'h00, 8'h01, 8'd255, 8'hC3, 256, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", {24'd0, bus.memAddress}, 0);
        check("rst_we", {31'd0, bus.memWriteEn}, 0);
        check("rst_dout", {24'd0, bus.memDataOut}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run(vecs[i]);

        // explicit spot checks from the wrap and overlap cases (vec 8 later overwrote memory)
        begin
            vec_t v;
            v = '{1'b1, 8'h00, 8'hFE, 8'd3, 8'h5C, 4, 1'b0};
            mem[8'h01] = 8'h9A; ref_mem[8'h01] = 8'h9A;
            run(v);
            check("wrap_ff", {24'd0, mem[8'hFF]}, 32'h5C);
            check("wrap_00", {24'd0, mem[8'h00]}, 32'h5C);
            check("wrap_01_kept", {24'd0, mem[8'h01]}, 32'h9A);
            mem[8'h40] = 8'h77; ref_mem[8'h40] = 8'h77;
            v = '{1'b0, 8'h40, 8'h41, 8'd3, 8'h00, 7, 1'b0};
            run(v);
            check("overlap_43", {24'd0, mem[8'h43]}, 32'h77);
        end

        // reset mid-copy after two bytes have been written
        begin
            vec_t v;
            int w0;
            int done_seen = 0;
            v = '{1'b0, 8'h50, 8'h90, 8'd8, 8'h00, 17, 1'b0};
            push_expected(v, 2);
            w0 = wr_count;
            drive_start(v);
            repeat (4) @(negedge clk);
            check("pre_rst_we", {31'd0, bus.memWriteEn}, 1);
            check("pre_rst_addr", {24'd0, bus.memAddress}, 32'h91);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("post_rst_busy", {31'd0, busy}, 0);
            check("post_rst_we", {31'd0, bus.memWriteEn}, 0);
            check("post_rst_addr", {24'd0, bus.memAddress}, 0);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done || busy) done_seen++;
            end
            check("post_rst_quiet", done_seen, 0);
            check("post_rst_writes", wr_count - w0, 2);
            compare_mem("post_rst_mem");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
